fifo_uart_tx: RTL
=================

# fifo_uart_tx

Serial transmitter that drains a word-wide FIFO onto a single UART line. It is the read-side companion of the button-driven FIFO test path: whenever the FIFO is non-empty, the block pops one word, frames it with start and stop bits, and shifts it out LSB-first at a rate set by an internal oversampling tick generator. It sits between a `fifo` instance (its `r_data`/`empty`/`rd` port) and a board TX pin.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `DVSR`, 163: clk cycles per oversampling tick (50 MHz / (16 × 19200)); must be at least 2.
- `DVSR_W`, 8: width of the tick divider counter; must satisfy 2^DVSR_W > DVSR.

- `clk`  in  1: single clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `empty`  in  1: FIFO empty flag.
- `r_data`  in  DBIT: FIFO head word, valid whenever `empty` = 0 (first-word-fall-through).
- `rd`  out  1: one-cycle pop strobe to the FIFO.
- `tx`  out  1: serial line, idle high.
- `tx_busy`  out  1: high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `tx` = 1.
  - If `empty` = 0: load `r_data` into the shift register, assert `rd` for this cycle only, clear the divider and tick count, then go to START.
  - Otherwise stay in IDLE.
- START: `tx` = 0 for 16 ticks, then go to DATA with the bit count at 0.
- DATA: `tx` = shift register bit 0.
  - After 16 ticks, shift right by one and increment the bit count.
  - After DBIT bits, go to STOP.
- STOP: `tx` = 1 for SB_TICK ticks, then go to IDLE.
- Tick generator: counts 0..DVSR-1 and pulses on DVSR-1. It runs only outside IDLE and is held at 0 in IDLE.
- The tick counter (4 bits plus enough range for SB_TICK) and the bit counter (covering 0..DBIT-1) reset at each state change.
- `tx` is driven from a register, so the output is glitch-free.
- `tx_busy` is 1 when state ≠ IDLE.
- `rd` is never asserted outside IDLE. It is never asserted when `empty` = 1, and never on two consecutive cycles.

## Timing
- Reset values: `tx` = 1, `rd` = 0, `tx_busy` = 0, state IDLE, all counters 0, shift register 0.
- Pop to start bit: `rd` is high in cycle N, and `tx` falls at the edge ending cycle N (it is low from cycle N+1).
- Bit periods: each start or data bit lasts exactly 16·DVSR clk. The stop period lasts exactly SB_TICK·DVSR clk.
- Frame length: (16·(1+DBIT) + SB_TICK)·DVSR clk, plus one IDLE cycle.
- Back-to-back frames: with the FIFO continuously non-empty, consecutive frames are separated by exactly one clk of `tx` = 1 beyond the stop period.
- Changes to `empty`/`r_data` mid-frame have no effect; the word is captured at pop.
- Reset asserted mid-frame:
  - `tx` goes high immediately (asynchronous).
  - The popped word is lost; it is not re-read.
  - After release, transmission resumes with the next FIFO word.
- A FIFO write in the same cycle as `rd` is the FIFO's concern; this block only requires `r_data` to be stable in the pop cycle.

## Structure
- Shared package `fifo_uart_pkg`:
  - state encoding (IDLE/START/DATA/STOP, 2-bit);
  - default baud constants (`DVSR_19200_50MHZ` = 163, `OVERSAMPLE` = 16).
- Sub-module `baud_tick_gen` (parameters DVSR, DVSR_W):
  - ports: `clk`, `reset`, `clr`, `tick`;
  - `clr` is held high in IDLE.
- The FSM and datapath stay in `fifo_uart_tx`.

## Test plan
The bench uses DVSR = 4, DBIT = 8, SB_TICK = 16, which gives 640-clk frames plus 1 idle clk.
- Reset, FIFO empty for 1000 clk -> `tx` = 1, `rd` = 0, `tx_busy` = 0 throughout.
- Single word 0xA5 in FIFO -> one `rd` pulse, then `tx` at 64-clk periods shows 0, 1,0,1,0,0,1,0,1, 1, then returns idle. `tx_busy` is high for 640 clk.
- Words 0x00, 0xFF, 0x3C preloaded -> exactly 3 `rd` pulses, spaced 641 clk apart. Decoded bytes match in order, and the FIFO reads empty after the third pop.
- `reset` driven low at clk 200 of a 0x55 frame -> `tx` = 1 in the same cycle and `tx_busy` = 0. After release with the FIFO holding 0x81, the next frame carries 0x81.
- Word written while busy (FIFO was empty after the first pop) -> no `rd` until the current stop period ends. `rd` then follows exactly 1 clk after `tx_busy` falls.
- SB_TICK = 32 rerun -> stop high for 128 clk and frame spacing 705 clk.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state encoding
// and default baud-rate constants.
package fifo_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int DVSR_19200_50MHZ = 163;
    localparam int OVERSAMPLE       = 16;

    // Bits needed for a counter running 0..count-1, never less than one.
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick divider: pulses once every DVSR clocks while not cleared.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int DVSR   = DVSR_19200_50MHZ,
    parameter int DVSR_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [DVSR_W-1:0] DIV_LAST = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] div_q;
    logic [DVSR_W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DVSR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = !clr && (div_q == DIV_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a first-word-fall-through FIFO and
// shifts each one out LSB-first between a start bit and a stop period.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = DVSR_19200_50MHZ,
    parameter int DVSR_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            empty,
    input  logic [DBIT-1:0] r_data,
    output logic            rd,
    output logic            tx,
    output logic            tx_busy
);

    localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int S_W   = cnt_width(S_MAX);
    localparam int N_W   = cnt_width(DBIT);

    localparam logic [S_W-1:0] OS_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] BIT_LAST  = N_W'(DBIT - 1);

    tx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_cnt_q, s_cnt_d;
    logic [N_W-1:0]  n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            tick;
    logic            pop;

    baud_tick_gen #(
        .DVSR   (DVSR),
        .DVSR_W (DVSR_W)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == ST_IDLE),
        .tick  (tick)
    );

    // Gated by reset so no word is popped (and lost) while held in reset.
    assign pop = reset && (state_q == ST_IDLE) && !empty;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shreg_d = r_data;
                    s_cnt_d = '0;
                    n_cnt_d = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == OS_LAST) begin
                        s_cnt_d = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_cnt_q == BIT_LAST) begin
                            n_cnt_d = '0;
                            state_d = ST_STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + N_W'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        s_cnt_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the next state so tx changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign rd      = pop;
    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);

endmodule
